// File: rtl/tx_serial_pkg.sv
// tx_serial_n shared types and helpers.
// FSM encoding, parity modes, frame length.
package tx_serial_pkg;

  typedef enum logic [1:0] {
    INICIAL     = 2'b00,
    PREPARA     = 2'b01,
    TRANSMISSAO = 2'b10,
    FINAL       = 2'b11
  } estado_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // start + data + optional parity + 1 or 2 stops
  function automatic logic [3:0] frame_len(
    input int unsigned db,
    input logic [1:0]  modo,
    input logic        ds
  );
    int unsigned n;
    n = 1 + db + (ds ? 2 : 1);
    if (modo == PAR_EVEN || modo == PAR_ODD)
      n = n + 1;
    return 4'(n);
  endfunction

endpackage

// File: rtl/tx_serial_n_if.sv
// tx_serial_n request/line bundle.
// master = requester, slave = transmitter.
interface tx_serial_n_if #(
  parameter int DATA_BITS = 7
);
  logic                 partida;
  logic [DATA_BITS-1:0] dados;
  logic [1:0]           paridade_modo;
  logic                 dois_stop;
  logic                 saida_serial;
  logic                 ocupado;
  logic                 pronto;
  logic [1:0]           db_estado;

  modport master (
    output partida, dados, paridade_modo, dois_stop,
    input  saida_serial, ocupado, pronto, db_estado
  );

  modport slave (
    input  partida, dados, paridade_modo, dois_stop,
    output saida_serial, ocupado, pronto, db_estado
  );
endinterface

// File: rtl/gerador_tick.sv
// Bit-period counter for tx_serial_n.
// Pulses tick_o on the last cycle of each bit.
module gerador_tick #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 13
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  logic [CNT_W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // count 0..CLKS_PER_BIT-1 while enabled, clear wins
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else if (clr_i)
      cnt_q <= '0;
    else if (en_i)
      cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
  end

endmodule

// File: rtl/tx_serial_n.sv
// Async serial transmitter: control FSM
// plus frame shift register.
module tx_serial_n
  import tx_serial_pkg::*;
#(
  parameter int DATA_BITS    = 7,
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 13
) (
  input  logic       clock,
  input  logic       reset,
  tx_serial_n_if.slave bus
);

  localparam int W = DATA_BITS + 4;

  estado_t        estado_q;
  logic [W-1:0]   sr_q;
  logic [W-1:0]   frame_d;
  logic [3:0]     bit_q;
  logic [3:0]     len_q;
  logic [3:0]     len_d;
  logic           pronto_q;
  logic           tick;

  gerador_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .clr_i (estado_q == PREPARA),
    .en_i  (estado_q == TRANSMISSAO),
    .tick_o(tick)
  );

  // compose frame LSB-first; unused high bits idle as ones
  always_comb begin
    frame_d                = '1;
    frame_d[0]             = 1'b0;
    frame_d[DATA_BITS:1]   = bus.dados;
    if (bus.paridade_modo == PAR_EVEN)
      frame_d[DATA_BITS+1] = ^bus.dados;
    else if (bus.paridade_modo == PAR_ODD)
      frame_d[DATA_BITS+1] = ~^bus.dados;
    len_d = frame_len(DATA_BITS, bus.paridade_modo,
                      bus.dois_stop);
  end

  // control FSM, shift register and completion pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
      sr_q     <= '1;
      bit_q    <= '0;
      len_q    <= '0;
      pronto_q <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      unique case (estado_q)
        INICIAL: begin
          if (bus.partida)
            estado_q <= PREPARA;
        end
        PREPARA: begin
          sr_q     <= frame_d;
          len_q    <= len_d;
          bit_q    <= '0;
          estado_q <= TRANSMISSAO;
        end
        TRANSMISSAO: begin
          if (tick) begin
            sr_q  <= {1'b1, sr_q[W-1:1]};
            bit_q <= bit_q + 4'd1;
            if (bit_q == len_q - 4'd1) begin
              estado_q <= FINAL;
              pronto_q <= 1'b1;
            end
          end
        end
        FINAL: begin
          estado_q <= INICIAL;
        end
      endcase
    end
  end

  assign bus.saida_serial = sr_q[0];
  assign bus.ocupado      = (estado_q != INICIAL);
  assign bus.pronto       = pronto_q;
  assign bus.db_estado    = estado_q;

endmodule

// File: tb/tb_tx_serial_n.sv
// Bench for tx_serial_n: per-cycle waveform
// model for a 7-bit and an 8-bit instance.
module tb_tx_serial_n;

  localparam int CPB = 4;
  localparam int N   = 2048;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   gcyc  = 0;
  int   vec   = 0;
  int   err   = 0;
  bit   chk_en = 1'b0;

  logic       e_line [0:1][0:N-1];
  logic       e_ocup [0:1][0:N-1];
  logic       e_pron [0:1][0:N-1];
  logic [1:0] e_st   [0:1][0:N-1];

  always #5 clock = ~clock;

  always @(posedge clock) gcyc <= gcyc + 1;

  tx_serial_n_if #(.DATA_BITS(7)) if7 ();
  tx_serial_n_if #(.DATA_BITS(8)) if8 ();

  tx_serial_n #(
    .DATA_BITS(7), .CLKS_PER_BIT(CPB), .CNT_W(3)
  ) dut7 (
    .clock(clock), .reset(reset), .bus(if7)
  );

  tx_serial_n #(
    .DATA_BITS(8), .CLKS_PER_BIT(CPB), .CNT_W(3)
  ) dut8 (
    .clock(clock), .reset(reset), .bus(if8)
  );

  task automatic cmp(input string nm, input int d,
                     input logic [1:0] got,
                     input logic [1:0] want);
    vec++;
    if (got !== want) begin
      err++;
      $display("FAIL %s dut%0d cyc=%0d got=%b want=%b",
               nm, d, gcyc, got, want);
    end
  endtask

  task automatic set_e(input int d, input int i,
                       input logic l, input logic o,
                       input logic p, input logic [1:0] s);
    if (i >= 0 && i < N) begin
      e_line[d][i] = l;
      e_ocup[d][i] = o;
      e_pron[d][i] = p;
      e_st[d][i]   = s;
    end
  endtask

  // expected waveform of one frame requested in cycle t
  task automatic plan(input int d, input int t,
                      input logic [8:0] dat, input int nb,
                      input logic [1:0] modo, input bit ds);
    bit q[$];
    bit p;
    int b;
    p = 1'b0;
    q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      q.push_back(dat[i]);
      p ^= dat[i];
    end
    if (modo == 2'b01) q.push_back(p);
    else if (modo == 2'b10) q.push_back(~p);
    q.push_back(1'b1);
    if (ds) q.push_back(1'b1);
    b = q.size();
    set_e(d, t + 1, 1'b1, 1'b1, 1'b0, 2'd1);
    for (int i = 0; i < b; i++)
      for (int k = 0; k < CPB; k++)
        set_e(d, t + 2 + i*CPB + k, q[i], 1'b1, 1'b0, 2'd2);
    set_e(d, t + 2 + b*CPB, 1'b1, 1'b1, 1'b1, 2'd3);
  endtask

  task automatic abort_from(input int d, input int t);
    for (int i = t; i < N; i++)
      set_e(d, i, 1'b1, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic goto(input int c);
    while (gcyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    goto(c);
    @(negedge clock);
  endtask

  // per-cycle check of both instances against the model
  always @(negedge clock) begin
    if (chk_en && gcyc < N) begin
      cmp("line", 0, {1'b0, if7.saida_serial},
          {1'b0, e_line[0][gcyc]});
      cmp("ocup", 0, {1'b0, if7.ocupado},
          {1'b0, e_ocup[0][gcyc]});
      cmp("pronto", 0, {1'b0, if7.pronto},
          {1'b0, e_pron[0][gcyc]});
      cmp("estado", 0, if7.db_estado, e_st[0][gcyc]);
      cmp("line", 1, {1'b0, if8.saida_serial},
          {1'b0, e_line[1][gcyc]});
      cmp("ocup", 1, {1'b0, if8.ocupado},
          {1'b0, e_ocup[1][gcyc]});
      cmp("pronto", 1, {1'b0, if8.pronto},
          {1'b0, e_pron[1][gcyc]});
      cmp("estado", 1, if8.db_estado, e_st[1][gcyc]);
    end
  end

  int t0;

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++)
        set_e(d, i, 1'b1, 1'b0, 1'b0, 2'd0);
    if7.partida = 0; if7.dados = 7'h35;
    if7.paridade_modo = 2'b01; if7.dois_stop = 1;
    if8.partida = 0; if8.dados = 8'hFF;
    if8.paridade_modo = 2'b01; if8.dois_stop = 0;

    #3 reset = 1'b0;
    @(negedge clock);
    cmp("rst_line", 0, {1'b0, if7.saida_serial}, 2'd1);
    cmp("rst_ocup", 0, {1'b0, if7.ocupado}, 2'd0);
    cmp("rst_pronto", 0, {1'b0, if7.pronto}, 2'd0);
    cmp("rst_estado", 0, if7.db_estado, 2'd0);
    cmp("rst_line", 1, {1'b0, if8.saida_serial}, 2'd1);
    cmp("rst_ocup", 1, {1'b0, if8.ocupado}, 2'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    chk_en = 1'b1;

    // 1: 0x35, even parity, two stops
    t0 = gcyc + 2;
    goto(t0);
    if7.partida = 1;
    plan(0, t0, 9'h035, 7, 2'b01, 1'b1);
    goto(t0 + 1); if7.partida = 0;
    at_neg(t0 + 14);
    cmp("t1_d2", 0, {1'b0, if7.saida_serial}, 2'd1);
    at_neg(t0 + 18);
    cmp("t1_d3", 0, {1'b0, if7.saida_serial}, 2'd0);
    at_neg(t0 + 35);
    cmp("t1_par", 0, {1'b0, if7.saida_serial}, 2'd0);
    at_neg(t0 + 45);
    cmp("t1_nopr", 0, {1'b0, if7.pronto}, 2'd0);
    at_neg(t0 + 46);
    cmp("t1_pr", 0, {1'b0, if7.pronto}, 2'd1);
    at_neg(t0 + 47);
    cmp("t1_idle", 0, {1'b0, if7.ocupado}, 2'd0);
    goto(t0 + 55);

    // 2a: odd parity, one stop
    t0 = gcyc + 2;
    goto(t0);
    if7.paridade_modo = 2'b10; if7.dois_stop = 0;
    if7.partida = 1;
    plan(0, t0, 9'h035, 7, 2'b10, 1'b0);
    goto(t0 + 1); if7.partida = 0;
    at_neg(t0 + 35);
    cmp("t2_par", 0, {1'b0, if7.saida_serial}, 2'd1);
    at_neg(t0 + 42);
    cmp("t2_pr", 0, {1'b0, if7.pronto}, 2'd1);
    goto(t0 + 50);

    // 2b: mode 11 means no parity
    t0 = gcyc + 2;
    goto(t0);
    if7.paridade_modo = 2'b11;
    if7.partida = 1;
    plan(0, t0, 9'h035, 7, 2'b11, 1'b0);
    goto(t0 + 1); if7.partida = 0;
    at_neg(t0 + 33);
    cmp("t2b_d6", 0, {1'b0, if7.saida_serial}, 2'd0);
    at_neg(t0 + 38);
    cmp("t2b_pr", 0, {1'b0, if7.pronto}, 2'd1);
    goto(t0 + 45);

    // 3: late dados change and partida ignored
    t0 = gcyc + 2;
    goto(t0);
    if7.paridade_modo = 2'b01; if7.dois_stop = 1;
    if7.partida = 1;
    plan(0, t0, 9'h035, 7, 2'b01, 1'b1);
    goto(t0 + 1); if7.partida = 0;
    goto(t0 + 10); if7.dados = 7'h00;
    goto(t0 + 20); if7.partida = 1;
    goto(t0 + 21); if7.partida = 0;
    at_neg(t0 + 46);
    cmp("t3_pr", 0, {1'b0, if7.pronto}, 2'd1);
    at_neg(t0 + 50);
    cmp("t3_idle", 0, {1'b0, if7.ocupado}, 2'd0);
    goto(t0 + 60);
    if7.dados = 7'h35;

    // 4: asynchronous reset mid-frame
    t0 = gcyc + 2;
    goto(t0);
    if7.partida = 1;
    plan(0, t0, 9'h035, 7, 2'b01, 1'b1);
    goto(t0 + 1); if7.partida = 0;
    goto(t0 + 17);
    abort_from(0, t0 + 17);
    reset = 1'b0;
    #1;
    cmp("t4_line", 0, {1'b0, if7.saida_serial}, 2'd1);
    cmp("t4_ocup", 0, {1'b0, if7.ocupado}, 2'd0);
    goto(t0 + 18); reset = 1'b1;
    goto(t0 + 25);
    if7.partida = 1;
    plan(0, t0 + 25, 9'h035, 7, 2'b01, 1'b1);
    goto(t0 + 26); if7.partida = 0;
    at_neg(t0 + 71);
    cmp("t4_pr", 0, {1'b0, if7.pronto}, 2'd1);
    goto(t0 + 80);

    // 5: partida held high, back-to-back frames
    t0 = gcyc + 2;
    goto(t0);
    if7.partida = 1;
    plan(0, t0, 9'h035, 7, 2'b01, 1'b1);
    plan(0, t0 + 47, 9'h035, 7, 2'b01, 1'b1);
    at_neg(t0 + 46);
    cmp("t5_pr1", 0, {1'b0, if7.pronto}, 2'd1);
    at_neg(t0 + 48);
    cmp("t5_gap", 0, {1'b0, if7.saida_serial}, 2'd1);
    at_neg(t0 + 49);
    cmp("t5_st2", 0, {1'b0, if7.saida_serial}, 2'd0);
    goto(t0 + 93); if7.partida = 0;
    at_neg(t0 + 93);
    cmp("t5_pr2", 0, {1'b0, if7.pronto}, 2'd1);
    goto(t0 + 110);

    // 6: 8-bit instance, 0xFF, even parity, one stop
    t0 = gcyc + 2;
    goto(t0);
    if8.partida = 1;
    plan(1, t0, 9'h0FF, 8, 2'b01, 1'b0);
    goto(t0 + 1); if8.partida = 0;
    at_neg(t0 + 41);
    cmp("t6_par", 1, {1'b0, if8.saida_serial}, 2'd0);
    at_neg(t0 + 45);
    cmp("t6_stop", 1, {1'b0, if8.saida_serial}, 2'd1);
    at_neg(t0 + 46);
    cmp("t6_pr", 1, {1'b0, if8.pronto}, 2'd1);
    goto(t0 + 55);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, err);
    $finish;
  end

endmodule

// File: doc/tx_serial_n.md
Name: tx_serial_n

Overview:
Parametrised asynchronous serial transmitter with its own control unit and bit-period counter. It sends one frame per request, with a compile-time number of data bits and run-time selection of parity (none/even/odd) and stop bits (1/2). A one-cycle `pronto` pulse marks completion. It replaces the fixed 7-bit, 2-stop datapath plus external-FSM arrangement in the serial-port experiments.

Parameters:
DATA_BITS, 7, number of data bits per frame (5..9), sent LSB first
CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); must be >= 2
CNT_W, 13, width of the bit-period counter; must satisfy 2**CNT_W >= CLKS_PER_BIT

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
partida  input  1  transmit request, sampled only in INICIAL
dados  input  DATA_BITS  word to send, captured at PREPARA
paridade_modo  input  2  00 none, 01 even, 10 odd, 11 treated as none; captured at PREPARA
dois_stop  input  1  1 = two stop bits, 0 = one; captured at PREPARA
saida_serial  output  1  serial line, registered, idles high
ocupado  output  1  high whenever state is not INICIAL
pronto  output  1  one-cycle pulse in FINAL
db_estado  output  2  current FSM state encoding, for the debug display

Behaviour:
- Reset (reset=0, asynchronous): state=INICIAL, saida_serial=1, ocupado=0, pronto=0, counters=0, shift register all ones. This applies immediately, including mid-frame. The partial frame is abandoned and the line goes high.
- Frame format, in time order:
  - start bit 0
  - dados[0] .. dados[DATA_BITS-1]
  - parity bit, if enabled: even = ^dados, odd = ~^dados
  - stop bit(s) 1
- Frame length B = 1 + DATA_BITS + P + S, where P is 0/1 and S is 1/2.
- FSM states: INICIAL(00), PREPARA(01), TRANSMISSAO(10), FINAL(11).
  - INICIAL: partida=1 -> PREPARA; otherwise stay. saida_serial=1.
  - PREPARA (1 cycle): load shift register with the composed frame; latch mode and stop configuration; clear bit-period and bit counters -> TRANSMISSAO.
  - TRANSMISSAO:
    - The bit-period counter counts 0..CLKS_PER_BIT-1.
    - At terminal count: shift right, filling with 1; increment bit counter.
    - After the B-th bit has been held CLKS_PER_BIT cycles -> FINAL.
  - FINAL (1 cycle): pronto=1, saida_serial=1 -> INICIAL.
- Latency:
  - partida sampled at edge t -> PREPARA at t+1 -> saida_serial=0 from t+2.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - pronto is high during cycle t+2+B*CLKS_PER_BIT.
- partida while ocupado=1 is ignored; no queuing.
- Changes to dados, paridade_modo or dois_stop after PREPARA do not affect the frame in flight.
- partida held high continuously: the next frame starts immediately after INICIAL. The gap between frames is exactly 3 idle-high cycles beyond the last stop bit (FINAL, INICIAL, PREPARA).
- saida_serial is always driven from a flop: no glitches, never X after reset.
- The bit counter wraps only via PREPARA and never exceeds B.

Decomposition:
- Shared package (tx_serial_pkg):
  - FSM state encodings
  - paridade_modo constants (PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10)
  - function returning frame length from DATA_BITS, parity and stop configuration
- Sub-module gerador_tick:
  - parametrised by CLKS_PER_BIT/CNT_W
  - synchronous clear, enable, one-cycle tick at terminal count
  - same async active-low reset
- FSM and shift register stay in tx_serial_n.

Test Plan:
1. CLKS_PER_BIT=4, DATA_BITS=7, dados=7'h35, even parity, dois_stop=1, partida pulse at t=0 -> saida_serial 0 on cycles 2..5; then bits 1,0,1,0,1,1,0,0(parity),1,1, each 4 cycles; pronto high at cycle 46 only; ocupado high cycles 1..46.
2. Same word, odd parity, dois_stop=0 -> parity bit 1; B=10; pronto at cycle 42. Same word, mode 11 -> no parity bit; B=9; pronto at cycle 38.
3. During frame of test 1: pulse partida at cycle 20 and change dados to 7'h00 at cycle 10 -> waveform identical to test 1; no second frame.
4. Assert reset=0 at cycle 17 for 1 cycle -> saida_serial=1, ocupado=0 in the same cycle (asynchronous); no pronto; next partida produces a full correct frame.
5. partida held high, two frames -> second start bit begins at cycle 49 (3 idle cycles after the last stop bit ends at cycle 45); two pronto pulses, at cycles 46 and 93.
6. DATA_BITS=8, dados=8'hFF, even parity, 1 stop -> bits 0, eight 1s, parity 0, stop 1; B=11; pronto at cycle 46.
